glycemic_sample_controller: RTL and testbench
=============================================

Name: glycemic_sample_controller

Overview:
Sequencer that owns the glycemic index calculator's input and output. It periodically, or on demand, latches the 8-bit blood sensor reading and drives it into the combinational calculator. It waits a settle window, then captures the 4-bit glycemic index. It offers the result downstream over a valid/ready handshake and tracks consecutive high readings to raise an alarm. It sits between the sensor front-end and the display/telemetry consumer.

Parameters:
- SAMPLE_PERIOD, 1000: clock cycles between automatic sample requests (>=2).
- SETTLE_CYCLES, 2: cycles calc_sensor is held before calc_index is captured (>=1).
- HIGH_THRESHOLD, 10: a captured index >= this value counts as high (4-bit).
- ALARM_COUNT, 3: consecutive high captures that assert alarm (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  allows period ticks and start_req to create requests.
- start_req  input  1  single-cycle manual sample request.
- sensor_in  input  8  raw blood sensor reading.
- calc_sensor  output  8  registered drive to the calculator's bloodSensor input.
- calc_index  input  4  calculator's glycemicIndex output.
- index_out  output  4  reported index.
- index_valid  output  1  index_out is valid.
- index_ready  input  1  consumer accepts index_out.
- alarm  output  1  high-streak alarm.
- busy  output  1  FSM is not in IDLE.
- overrun  output  1  one-cycle pulse when a request is merged into an already-pending one.
- sample_count  output  8  number of completed handshakes, wraps modulo 256.

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs, the FSM, the period counter, pending, the streak counter and the history are cleared to 0 immediately. Reset mid-transaction aborts the transaction; no partial result is reported.
- Period counter:
  - While enable=1 it counts 0..SAMPLE_PERIOD-1 and wraps to 0.
  - The wrap cycle is the tick.
  - While enable=0 the counter is held at 0.
- Pending flag:
  - Set on (tick | start_req) & enable.
  - Cleared on the cycle the FSM leaves IDLE. If set and clear coincide, set wins only when the FSM is not leaving IDLE that cycle.
  - A request that arrives while pending=1 and the FSM is not leaving IDLE causes overrun=1 for one cycle; the request is merged, not queued.
- FSM states: IDLE, LATCH, SETTLE, CAPTURE, REPORT.
  - IDLE: goes to LATCH when pending=1.
  - LATCH: calc_sensor <= sensor_in, then go to SETTLE.
  - SETTLE: stays SETTLE_CYCLES cycles; calc_sensor is held.
  - CAPTURE: samples calc_index, updates the streak counter and the history, then goes to REPORT.
  - REPORT: index_valid=1. On index_valid & index_ready, go to IDLE and increment sample_count.
- Latency: with the first IDLE cycle that sees pending=1 as cycle 0, index_valid rises at cycle 3+SETTLE_CYCLES. busy=1 in every state except IDLE.
- Handshake:
  - index_out is stable while index_valid=1 and index_ready=0.
  - index_ready while index_valid=0 is ignored.
  - index_valid deasserts the cycle after acceptance.
  - The minimum interval between accepted results is 4+SETTLE_CYCLES cycles.
- Alarm:
  - The 4-bit streak counter saturates at 15.
  - A raw captured index >= HIGH_THRESHOLD increments the counter; any other captured index clears it.
  - alarm is registered: alarm = (streak >= ALARM_COUNT), updated on the capture cycle. It clears on the next below-threshold capture.
- Dropping enable mid-transaction completes the current transaction, including REPORT. No new requests are created; a request already pending is still serviced.
- calc_sensor keeps its last value in IDLE.

Optional Feature:
- Macro: GLY_AVERAGE_EN.
- Defined: a 4-entry history (reset 0) shifts in each raw capture. index_out = (sum of the 4 entries, 6-bit) >> 2, truncated. Entries start at 0, so the first three results are diluted. Alarm still uses the raw index.
- Undefined: no history logic; index_out = raw captured calc_index.

Test Plan:
- SAMPLE_PERIOD=8, SETTLE_CYCLES=2, enable=1, index_ready=1, calc_index modeled as sensor_in>>4, sensor_in=8'hA0 -> index_out=4'hA. index_valid rises 5 cycles after IDLE sees pending. sample_count increments every 8 cycles.
- start_req pulse while enable=0 -> no transaction, busy stays 0. The same pulse with enable=1 -> one transaction; calc_sensor equals sensor_in at the LATCH cycle even if sensor_in changes during SETTLE.
- index_ready=0 for 20 cycles in REPORT -> index_valid and index_out held. Extra ticks during the stall produce exactly one overrun pulse per merged request and one follow-up transaction after acceptance.
- Captures of 4'd12, 4'd11, 4'd15 -> alarm=1 after the third capture. A following capture of 4'd3 -> alarm=0 on the cycle after that capture.
- rst_n pulled low during SETTLE -> outputs 0 immediately with no clock edge. After release, normal operation resumes with sample_count=0.
- GLY_AVERAGE_EN defined, raw captures 8, 8, 8, 8 -> index_out = 2, 4, 6, 8.

Source files
------------

// File: rtl/glycemic_sample_controller.sv
// Sequencer for the glycemic index calculator: request, latch sensor, settle, capture, report.
// Optional GLY_AVERAGE_EN: report the truncated average of the last four raw captures.
module glycemic_sample_controller #(
  parameter int unsigned SAMPLE_PERIOD  = 1000,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned HIGH_THRESHOLD = 10,
  parameter int unsigned ALARM_COUNT    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       start_req,
  input  logic [7:0] sensor_in,
  output logic [7:0] calc_sensor,
  input  logic [3:0] calc_index,
  output logic [3:0] index_out,
  output logic       index_valid,
  input  logic       index_ready,
  output logic       alarm,
  output logic       busy,
  output logic       overrun,
  output logic [7:0] sample_count
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_PERIOD);
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LATCH   = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_REPORT  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;
  logic              index_valid_q, index_valid_d;
  logic              alarm_q, alarm_d;
  logic [7:0]        calc_sensor_q, calc_sensor_d;
  logic [3:0]        index_out_q, index_out_d;
  logic [3:0]        streak_q, streak_d;
  logic [7:0]        sample_count_q, sample_count_d;
  logic              tick_c, req_c, leave_idle_c, accept_c;

`ifdef GLY_AVERAGE_EN
  logic [3:0][3:0]   hist_q, hist_d;
  logic [5:0]        avg_sum_c;

  // Sum of the incoming capture and the three newest history entries.
  assign avg_sum_c = 6'(calc_index) + 6'(hist_q[0]) + 6'(hist_q[1]) + 6'(hist_q[2]);
`endif

  assign tick_c       = enable && (period_cnt_q == CNT_W'(SAMPLE_PERIOD - 1));
  assign req_c        = enable && (tick_c || start_req);
  assign leave_idle_c = (state_q == S_IDLE) && pending_q;
  assign accept_c     = (state_q == S_REPORT) && index_valid_q && index_ready;

  // Free-running sample period counter, parked at 0 while disabled.
  always_comb begin
    period_cnt_d = '0;
    if (enable) begin
      period_cnt_d = tick_c ? '0 : period_cnt_q + CNT_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  // Next-state logic, including the settle window timer.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    unique case (state_q)
      S_IDLE:    if (pending_q) state_d = S_LATCH;
      S_LATCH: begin
        state_d      = S_SETTLE;
        settle_cnt_d = '0;
      end
      S_SETTLE: begin
        if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) state_d = S_CAPTURE;
        else                                          settle_cnt_d = settle_cnt_q + SET_W'(1);
      end
      S_CAPTURE: state_d = S_REPORT;
      S_REPORT:  if (accept_c) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    pending_d      = pending_q;
    overrun_d      = 1'b0;
    busy_d         = (state_d != S_IDLE);
    index_valid_d  = index_valid_q;
    alarm_d        = alarm_q;
    calc_sensor_d  = calc_sensor_q;
    index_out_d    = index_out_q;
    streak_d       = streak_q;
    sample_count_d = sample_count_q;
`ifdef GLY_AVERAGE_EN
    hist_d         = hist_q;
`endif

    // Leaving IDLE consumes the request; anything arriving now is merged into it.
    if (leave_idle_c)  pending_d = 1'b0;
    else if (req_c)    pending_d = 1'b1;
    overrun_d = req_c && pending_q && !leave_idle_c;

    unique case (state_q)
      S_LATCH: calc_sensor_d = sensor_in;
      S_CAPTURE: begin
        if (calc_index >= 4'(HIGH_THRESHOLD)) streak_d = (streak_q == 4'd15) ? 4'd15 : streak_q + 4'd1;
        else                                   streak_d = 4'd0;
        alarm_d       = (streak_d >= 4'(ALARM_COUNT));
        index_valid_d = 1'b1;
`ifdef GLY_AVERAGE_EN
        hist_d        = {hist_q[2:0], calc_index};
        index_out_d   = 4'(avg_sum_c >> 2);
`else
        index_out_d   = calc_index;
`endif
      end
      S_REPORT: begin
        if (accept_c) begin
          index_valid_d  = 1'b0;
          sample_count_d = sample_count_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt_q   <= '0;
      pending_q      <= 1'b0;
      overrun_q      <= 1'b0;
      busy_q         <= 1'b0;
      index_valid_q  <= 1'b0;
      alarm_q        <= 1'b0;
      calc_sensor_q  <= '0;
      index_out_q    <= '0;
      streak_q       <= '0;
      sample_count_q <= '0;
    end else begin
      period_cnt_q   <= period_cnt_d;
      pending_q      <= pending_d;
      overrun_q      <= overrun_d;
      busy_q         <= busy_d;
      index_valid_q  <= index_valid_d;
      alarm_q        <= alarm_d;
      calc_sensor_q  <= calc_sensor_d;
      index_out_q    <= index_out_d;
      streak_q       <= streak_d;
      sample_count_q <= sample_count_d;
    end
  end

`ifdef GLY_AVERAGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= '0;
    else        hist_q <= hist_d;
  end
`endif

  assign calc_sensor  = calc_sensor_q;
  assign index_out    = index_out_q;
  assign index_valid  = index_valid_q;
  assign alarm        = alarm_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign sample_count = sample_count_q;

endmodule

// File: tb/tb_glycemic_sample_controller.sv
// Directed and randomized bench for glycemic_sample_controller with a transaction-level reference model.
module tb_glycemic_sample_controller;

  logic       clk = 1'b0;
  logic       rst_n, enable, start_req, index_ready;
  logic [7:0] sensor_in, calc_sensor, sample_count;
  logic [3:0] calc_index, index_out;
  logic       index_valid, alarm, busy, overrun;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model state: streak of high captures, last raw captures, handshake count.
  int m_streak;
  int m_count;
  int m_hist[$];

  glycemic_sample_controller #(
    .SAMPLE_PERIOD(8), .SETTLE_CYCLES(2), .HIGH_THRESHOLD(10), .ALARM_COUNT(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start_req(start_req),
    .sensor_in(sensor_in), .calc_sensor(calc_sensor), .calc_index(calc_index),
    .index_out(index_out), .index_valid(index_valid), .index_ready(index_ready),
    .alarm(alarm), .busy(busy), .overrun(overrun), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  // Calculator stand-in: index is the upper nibble of the sensor drive.
  assign calc_index = calc_sensor[7:4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_streak = 0;
    m_count  = 0;
    m_hist   = '{0, 0, 0, 0};
  endtask

  task automatic model_capture(input int raw, output int exp_idx, output int exp_alarm);
    int sum;
    m_streak  = (raw >= 10) ? ((m_streak < 15) ? m_streak + 1 : 15) : 0;
    exp_alarm = (m_streak >= 3) ? 1 : 0;
    m_hist.push_back(raw);
    void'(m_hist.pop_front());
    sum = 0;
    foreach (m_hist[k]) sum += m_hist[k];
`ifdef GLY_AVERAGE_EN
    exp_idx = sum / 4;
`else
    exp_idx = raw;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; start_req = 1'b0; index_ready = 1'b0; sensor_in = 8'h00;
    step(); step();
    rst_n = 1'b1;
    step();
    model_clear();
  endtask

  // One start_req transaction with enable dropped right after; checks result, stall hold and handshake.
  task automatic do_txn(input logic [7:0] s, input int delay, output int got_idx);
    int exp_idx, exp_alarm;
    bit seen;
    logic [3:0] held;
    model_capture(int'(s[7:4]), exp_idx, exp_alarm);
    sensor_in = s; enable = 1'b1; start_req = 1'b1; index_ready = 1'($urandom_range(0, 1));
    step();
    start_req = 1'b0; enable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (index_valid) begin seen = 1'b1; break; end
      if (i >= 2) sensor_in = 8'($urandom);
      index_ready = 1'($urandom_range(0, 1));
    end
    chk("txn_valid_timeout", 32'(seen), 1);
    chk("txn_index", 32'(index_out), exp_idx);
    chk("txn_alarm", 32'(alarm), exp_alarm);
    chk("txn_busy", 32'(busy), 1);
    held = index_out;
    index_ready = 1'b0;
    for (int i = 0; i < delay; i++) begin
      step();
      chk("stall_valid", 32'(index_valid), 1);
      chk("stall_index", 32'(index_out), 32'(held));
    end
    index_ready = 1'b1;
    step();
    index_ready = 1'b0;
    m_count++;
    chk("accept_valid_low", 32'(index_valid), 0);
    chk("accept_busy_low", 32'(busy), 0);
    chk("sample_count", 32'(sample_count), m_count % 256);
    got_idx = int'(held);
  endtask

  initial begin
    int n, ov, got;
    bit hold_ok, quiet;
    logic [3:0] held;
    int alarm_exp[4];

    // Reset values
    rst_n = 1'b0; enable = 1'b0; start_req = 1'b0; index_ready = 1'b0; sensor_in = 8'h00;
    model_clear();
    step();
    chk("rst_index_valid", 32'(index_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_sample_count", 32'(sample_count), 0);
    chk("rst_calc_sensor", 32'(calc_sensor), 0);
    chk("rst_index_out", 32'(index_out), 0);
    rst_n = 1'b1;
    step();

    // start_req while disabled creates nothing
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (busy !== 1'b0) quiet = 1'b0;
    end
    chk("disabled_busy_stays_low", 32'(quiet), 1);
    chk("disabled_no_count", 32'(sample_count), 0);

    // Latency and periodic sampling with sensor A0
    sensor_in = 8'hA0; index_ready = 1'b1; enable = 1'b1; start_req = 1'b1;
    step();
    start_req = 1'b0;
    n = 0;
    while (!index_valid && n < 20) begin step(); n++; end
    chk("latency_cycles", n, 5);
    chk("period_index", 32'(index_out), 32'hA);
    n = 0;
    while (sample_count != 8'd2 && n < 40) begin step(); n++; end
    chk("period_reach_two", 32'(sample_count), 2);
    n = 0;
    while (sample_count != 8'd3 && n < 40) begin step(); n++; end
    chk("period_interval", n, 8);
    chk("period_index_again", 32'(index_out), 32'hA);
    do_reset();

    // calc_sensor holds the LATCH-cycle value while sensor_in moves during SETTLE
    sensor_in = 8'h55; enable = 1'b1; start_req = 1'b1; index_ready = 1'b0;
    step();
    start_req = 1'b0; enable = 1'b0;
    step();
    step();
    sensor_in = 8'hFF;
    chk("settle_calc_sensor_a", 32'(calc_sensor), 32'h55);
    step();
    chk("settle_calc_sensor_b", 32'(calc_sensor), 32'h55);
    n = 0;
    while (!index_valid && n < 20) begin step(); n++; end
    chk("settle_index", 32'(index_out), 32'h5);
    index_ready = 1'b1;
    step();
    index_ready = 1'b0;
    do_reset();

    // Stall in REPORT for 20 cycles while period ticks keep requesting
    sensor_in = 8'h70; index_ready = 1'b0; enable = 1'b1; start_req = 1'b1;
    step();
    start_req = 1'b0;
    n = 0;
    while (!index_valid && n < 20) begin step(); n++; end
    held = index_out;
    hold_ok = 1'b1;
    ov = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (overrun) ov++;
      if (index_valid !== 1'b1 || index_out !== held) hold_ok = 1'b0;
    end
    chk("stall_hold", 32'(hold_ok), 1);
    chk("stall_index_value", 32'(held), 32'h7);
    // Ticks land on enabled edges 8, 16, 24: the first sets pending, the other two merge.
    chk("stall_overrun_pulses", ov, 2);
    index_ready = 1'b1; enable = 1'b0;
    step();
    chk("stall_accept_count", 32'(sample_count), 1);
    n = 0;
    while (sample_count != 8'd2 && n < 30) begin step(); n++; end
    chk("followup_count", 32'(sample_count), 2);
    for (int i = 0; i < 20; i++) step();
    chk("no_extra_txn", 32'(sample_count), 2);
    chk("idle_after_followup", 32'(busy), 0);
    index_ready = 1'b0;

    // Asynchronous reset during SETTLE
    sensor_in = 8'hC0; enable = 1'b1; start_req = 1'b1;
    step();
    start_req = 1'b0; enable = 1'b0;
    step();
    step();
    chk("pre_reset_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_count", 32'(sample_count), 0);
    chk("async_rst_calc_sensor", 32'(calc_sensor), 0);
    chk("async_rst_valid", 32'(index_valid), 0);
    step();
    rst_n = 1'b1;
    model_clear();
    step();
    chk("post_reset_valid", 32'(index_valid), 0);
    do_txn(8'h20, 1, got);
    chk("post_reset_count", 32'(sample_count), 1);

    // Alarm streak: 12, 11, 15 raise it, 3 clears it
    alarm_exp = '{0, 0, 1, 0};
    do_txn(8'hC0, 0, got);  chk("alarm_after_12", 32'(alarm), alarm_exp[0]);
    do_txn(8'hB0, 2, got);  chk("alarm_after_11", 32'(alarm), alarm_exp[1]);
    do_txn(8'hF0, 0, got);  chk("alarm_after_15", 32'(alarm), alarm_exp[2]);
    do_txn(8'h30, 1, got);  chk("alarm_after_3", 32'(alarm), alarm_exp[3]);

`ifdef GLY_AVERAGE_EN
    // Averaging: four raw captures of 8 ramp up through the zeroed history
    do_reset();
    do_txn(8'h80, 0, got);  chk("avg_first", got, 2);
    do_txn(8'h80, 0, got);  chk("avg_second", got, 4);
    do_txn(8'h80, 0, got);  chk("avg_third", got, 6);
    do_txn(8'h80, 0, got);  chk("avg_fourth", got, 8);
`endif

    // Randomized transactions against the model
    do_reset();
    for (int t = 0; t < 40; t++) begin
      logic [7:0] s;
      s = 8'($urandom);
      if ($urandom_range(0, 1) == 1) s[7:6] = 2'b11;
      do_txn(s, int'($urandom_range(0, 4)), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
